alu_mul_seq: RTL and testbench

Multi-cycle shift-and-add multiply sequencer that borrows the single-cycle datapath's shared ALU and produces the low WIDTH bits of a product (RV32M MUL semantics). It sits beside the ALU in the execute stage. While busy it owns the ALU operand/control inputs through the datapath's operand mux, and it uses only the add operation (ALUctrl 3'b000) for accumulation. The ALU stays instantiated in the datapath; this block only sequences it.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_mul_seq.sv | 107 ++++++++++
 tb/tb_alu_mul_seq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer's state type.
// Also imported by the datapath control decoder.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_EQ  = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer: borrows the shared ALU adder for WIDTH
// cycles and returns the low WIDTH bits of opa*opb.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_sum,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [2:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t       state_q;
  mul_state_t       state_d;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] step_acc;

  assign accept    = start && !flush && (state_q != RUN);
  assign step      = (state_q == RUN) && !flush;
  assign last_step = step && (cnt == LAST_CNT);
  // The ALU adds acc + mcand combinationally; keep it only when the multiplier bit is set.
  assign step_acc  = mplier[0] ? alu_sum : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (flush)          state_d = IDLE;
        else if (last_step) state_d = DONE;
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_own = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    alu_op1 = '0;
    alu_op2 = '0;
    case (state_q)
      RUN: begin
        alu_own = 1'b1;
        busy    = 1'b1;
        alu_op1 = acc;
        alu_op2 = mcand;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctrl = ALU_ADD;

  // A flush in RUN freezes the working registers; the next accept reloads them anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= opa;
      mplier <= opb;
      cnt    <= '0;
    end else if (step) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_step) result <= step_acc;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboarded bench for alu_mul_seq with a behavioural shared-ALU adder.
module tb_alu_mul_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_own;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [2:0]       alu_ctrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  alu_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .opa(opa), .opb(opb), .alu_sum(alu_sum),
    .alu_own(alu_own), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_ctrl(alu_ctrl), .busy(busy), .done(done), .result(result)
  );

  // Shared ALU: combinational, only the add operation matters here.
  assign alu_sum = (alu_ctrl == 3'b000) ? alu_op1 + alu_op2 : '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 result=%h", result);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp, input bit push);
    exp_t e;
    @(negedge clk);
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.res = exp;
      e.cyc = cyc + WIDTH;
      sb.push_back(e);
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    WIDTH'(busy),    '0);
    check({tag, "_done"},    WIDTH'(done),    '0);
    check({tag, "_alu_own"}, WIDTH'(alu_own), '0);
    check({tag, "_op1"},     alu_op1,         '0);
    check({tag, "_op2"},     alu_op2,         '0);
    check({tag, "_result"},  result,          '0);
    check({tag, "_ctrl"},    WIDTH'(alu_ctrl), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   busy_cycles;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    opa   = '0;
    opb   = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 7*6: busy exactly WIDTH cycles, then the done cycle
    issue(32'd7, 32'd6, 32'd42, 1'b1);
    busy_cycles = 0;
    while (busy_cycles < 100) begin
      @(negedge clk);
      if (!busy) break;
      busy_cycles++;
    end
    check("busy_cycles", busy_cycles, 32);
    check("done_after_busy", WIDTH'(done), 1);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    wait_done();
    issue(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    wait_done();

    // start pulsed mid-RUN with new operands is ignored
    issue(32'd9, 32'd11, 32'd99, 1'b1);
    repeat (5) @(negedge clk);
    opa   = 32'd100;
    opb   = 32'd200;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);
    check("ignored_start_idle", WIDTH'(busy), 0);

    // flush at RUN cycle 10 keeps the previous result
    issue(32'd7, 32'd6, 32'd42, 1'b1);
    wait_done();
    issue(32'd1234, 32'd5, '0, 1'b0);
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_alu_own", WIDTH'(alu_own), 0);
    check("flush_busy", WIDTH'(busy), 0);
    check("flush_result", result, 32'd42);
    repeat (40) @(negedge clk);
    check("flush_result_held", result, 32'd42);

    // asynchronous reset at RUN cycle 5
    issue(32'd100, 32'd100, '0, 1'b0);
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'd3, 32'd5, 32'd15, 1'b1);
    wait_done();

    // start held high across done: back-to-back operations
    @(negedge clk);
    opa   = 32'd25;
    opb   = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = 32'd100;
    e.cyc = cyc + WIDTH;
    sb.push_back(e);
    e.res = 32'h2345_6780;
    e.cyc = cyc + 2 * WIDTH + 1;
    sb.push_back(e);
    opa = 32'h1234_5678;
    opb = 32'h0000_0010;
    wait_done();
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_rerun_busy", WIDTH'(busy), 1);
    wait_done();
    repeat (5) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
